// File: rtl/int8_mac_seq_pkg.sv
// rtl/int8_mac_seq_pkg.sv - shared FSM encoding and iteration constants for the int8 MAC
//
// Contents:
//   state_t      : sequencer states IDLE -> MUL -> SIGN -> ACC -> IDLE
//   MUL_ITERS    : shift-add iterations per multiply (one per multiplier bit)
//   ITER_CNT_W   : width of the iteration counter
package int8_mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SIGN = 2'd2,
    ACC  = 2'd3
  } state_t;

  localparam int MUL_ITERS  = 8;
  localparam int ITER_CNT_W = 3;

endpackage

// File: rtl/cond_neg.sv
// rtl/cond_neg.sv - conditional negate with one bit of sign growth
//
// Ports:
//   din  in  W    two's complement value
//   en   in  1    negate when high
//   dout out W+1  en ? -din : din, sign-extended by one bit so -2^(W-1) negates exactly
module cond_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  input  logic         en,
  output logic [W:0]   dout
);

  logic [W:0] din_ext;

  assign din_ext = {din[W-1], din};
  assign dout    = en ? (~din_ext + 1'b1) : din_ext;

endmodule

// File: rtl/neg16.sv
// rtl/neg16.sv - 16-bit conditional negate for the product sign fix
//
// Ports:
//   din  in  16  unsigned product magnitude (at most 16384, so never wraps)
//   en   in  1   negate when high
//   dout out 16  en ? -din : din
module neg16 (
  input  logic [15:0] din,
  input  logic        en,
  output logic [15:0] dout
);

  assign dout = en ? (~din + 16'd1) : din;

endmodule

// File: rtl/int8_mac_seq.sv
// rtl/int8_mac_seq.sv - sequential signed 8x8 multiply-accumulate with saturating accumulator
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request one multiply-accumulate of in_a*in_b (taken only when ready)
//   ready    out  1      high in IDLE
//   in_a     in   8      signed multiplicand
//   in_b     in   8      signed multiplier
//   acc_clr  in   1      clear acc and sat (IDLE only; applied before a same-cycle start)
//   acc      out  ACC_W  signed running sum of products
//   prod     out  16     signed product of the last completed operation
//   done     out  1      one-cycle pulse after acc has been updated
//   sat      out  1      sticky saturation flag
module int8_mac_seq
  import int8_mac_seq_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc,
  output logic [15:0]      prod,
  output logic             done,
  output logic             sat
);

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(MUL_ITERS - 1);

  state_t                  state;
  logic [ITER_CNT_W-1:0]   cnt;
  logic [15:0]             mcand;
  logic [8:0]              mplier;
  logic [15:0]             mag_p;
  logic                    sign;

  logic [8:0]              abs_a;
  logic [8:0]              abs_b;
  logic [15:0]             prod_fix;

  logic [ACC_W:0]          sum_ext;
  logic                    sum_ovf;
  logic [ACC_W-1:0]        acc_next;

  // Operand magnitudes: 9 bits so that -128 becomes +128 exactly.
  cond_neg #(.W(8)) u_abs_a (
    .din  (in_a),
    .en   (in_a[7]),
    .dout (abs_a)
  );

  cond_neg #(.W(8)) u_abs_b (
    .din  (in_b),
    .en   (in_b[7]),
    .dout (abs_b)
  );

  neg16 u_prod_sign (
    .din  (mag_p),
    .en   (sign),
    .dout (prod_fix)
  );

  // Saturating add: one guard bit; overflow when the top two sum bits disagree,
  // and the guard bit then gives the true sign of the clamp direction.
  assign sum_ext  = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - 16){prod[15]}}, prod};
  assign sum_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
  assign acc_next = sum_ovf ? (sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}})
                            : sum_ext[ACC_W-1:0];

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mag_p  <= '0;
      sign   <= 1'b0;
      prod   <= '0;
      acc    <= '0;
      sat    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_clr) begin
            acc <= '0;
            sat <= 1'b0;
          end
          if (start) begin
            mcand  <= {7'd0, abs_a};
            mplier <= abs_b;
            sign   <= in_a[7] ^ in_b[7];
            mag_p  <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          // One multiplier bit per cycle, LSB first; multiplicand shifts up in step.
          if (mplier[0]) begin
            mag_p <= mag_p + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == LAST_ITER) begin
            cnt   <= '0;
            state <= SIGN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SIGN: begin
          prod  <= prod_fix;
          state <= ACC;
        end
        ACC: begin
          acc <= acc_next;
          if (sum_ovf) begin
            sat <= 1'b1;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int8_mac_seq.sv
// tb/tb_int8_mac_seq.sv - self-checking bench for int8_mac_seq at ACC_W 24 and 17
module tb_int8_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        acc_clr;
  logic [7:0]  in_a;
  logic [7:0]  in_b;

  logic        ready24, done24, sat24;
  logic [23:0] acc24;
  logic [15:0] prod24;
  logic        ready17, done17, sat17;
  logic [16:0] acc17;
  logic [15:0] prod17;

  int checks = 0;
  int errors = 0;

  longint m_acc24, m_acc17, m_prod;
  bit     m_sat24, m_sat17;

  always #5 clk = ~clk;

  int8_mac_seq #(.ACC_W(24)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready24), .in_a(in_a), .in_b(in_b),
    .acc_clr(acc_clr), .acc(acc24), .prod(prod24), .done(done24), .sat(sat24)
  );

  int8_mac_seq #(.ACC_W(17)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready17), .in_a(in_a), .in_b(in_b),
    .acc_clr(acc_clr), .acc(acc17), .prod(prod17), .done(done17), .sat(sat17)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_op(input int a, input int b, input bit clr);
    longint s24, s17;
    if (clr) begin
      m_acc24 = 0; m_acc17 = 0; m_sat24 = 0; m_sat17 = 0;
    end
    m_prod = longint'(a) * longint'(b);
    s24 = m_acc24 + m_prod;
    s17 = m_acc17 + m_prod;
    m_acc24 = clamp(s24, 24);
    m_acc17 = clamp(s17, 17);
    if (m_acc24 != s24) m_sat24 = 1;
    if (m_acc17 != s17) m_sat17 = 1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_acc24"},  longint'($signed(acc24)),  m_acc24);
    check({tag, "_acc17"},  longint'($signed(acc17)),  m_acc17);
    check({tag, "_prod24"}, longint'($signed(prod24)), m_prod);
    check({tag, "_prod17"}, longint'($signed(prod17)), m_prod);
    check({tag, "_sat24"},  longint'(sat24), longint'(m_sat24));
    check({tag, "_sat17"},  longint'(sat17), longint'(m_sat17));
  endtask

  // Entered just after a falling edge; returns just after the falling edge that follows done.
  task automatic run_op(input int a, input int b, input bit clr, input bit inject, input string tag);
    longint prev24, prev17;
    bit     got;
    check({tag, "_ready"}, longint'({ready24, ready17}), 3);
    in_a    = 8'(a);
    in_b    = 8'(b);
    start   = 1'b1;
    acc_clr = clr;
    @(posedge clk); #1;
    check({tag, "_accept"}, longint'({ready24, ready17, done24, done17}), 0);
    prev24 = clr ? 0 : m_acc24;
    prev17 = clr ? 0 : m_acc17;
    model_op(a, b, clr);
    @(negedge clk);
    start   = 1'b0;
    acc_clr = 1'b0;
    in_a    = 8'($urandom);
    in_b    = 8'($urandom);
    got     = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (inject && k == 3) begin
        start   = 1'b1;
        acc_clr = 1'b1;
        in_a    = 8'($urandom);
        in_b    = 8'($urandom);
      end
      @(posedge clk); #1;
      if (k == 9) begin
        check({tag, "_hold24"}, longint'($signed(acc24)), prev24);
        check({tag, "_hold17"}, longint'($signed(acc17)), prev17);
      end
      if (done24 || done17) begin
        got = 1'b1;
        check({tag, "_lat"}, k, 10);
        check({tag, "_done_pair"}, longint'({done24, done17}), 3);
      end
      @(negedge clk);
      start   = 1'b0;
      acc_clr = 1'b0;
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
    check_state(tag);
  endtask

  task automatic clear_only(input string tag);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    m_acc24 = 0; m_acc17 = 0; m_sat24 = 0; m_sat17 = 0;
    check({tag, "_acc"}, longint'({acc24, acc17}), 0);
    check({tag, "_sat"}, longint'({sat24, sat17}), 0);
    @(negedge clk);
    acc_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  a, b, n_done;
    bit  clr, inj;
    rst_n   = 1'b0;
    start   = 1'b0;
    acc_clr = 1'b0;
    in_a    = '0;
    in_b    = '0;
    m_acc24 = 0; m_acc17 = 0; m_prod = 0; m_sat24 = 0; m_sat17 = 0;
    #1;
    check("rst_ready", longint'({ready24, ready17}), 3);
    check("rst_done", longint'({done24, done17}), 0);
    check_state("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    clear_only("clr0");
    run_op(3, -5, 1'b0, 1'b0, "op3x-5");
    check("op3x-5_prod_const", longint'($signed(prod24)), -15);
    check("op3x-5_acc_const", longint'($signed(acc24)), -15);

    run_op(-128, -128, 1'b1, 1'b0, "neg128sq");
    check("neg128sq_prod_const", longint'($signed(prod17)), 16384);
    run_op(-128, 127, 1'b0, 1'b0, "neg128x127");
    check("neg128x127_prod_const", longint'($signed(prod17)), -16256);
    check("neg128x127_acc_const", longint'($signed(acc17)), 128);

    run_op(127, 127, 1'b1, 1'b0, "sat0");
    for (int i = 1; i < 5; i++) run_op(127, 127, 1'b0, 1'b0, $sformatf("sat%0d", i));
    check("sat_clamp_acc17", longint'($signed(acc17)), 65535);
    check("sat_clamp_flag17", longint'(sat17), 1);
    run_op(-3, 7, 1'b0, 1'b0, "sat_sticky");
    clear_only("sat_clr");

    run_op(-77, 45, 1'b0, 1'b1, "inject");

    // Reset asserted just before E5 of an operation.
    in_a  = 8'd100;
    in_b  = 8'd50;
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_acc24 = 0; m_acc17 = 0; m_prod = 0; m_sat24 = 0; m_sat17 = 0;
    check("midrst_ready", longint'({ready24, ready17}), 3);
    check("midrst_done", longint'({done24, done17}), 0);
    check_state("midrst");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done24 || done17) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_ready_after", longint'({ready24, ready17}), 3);
    @(negedge clk);

    run_op(10, 100, 1'b1, 1'b0, "pre1000");
    check("pre1000_acc_const", longint'($signed(acc24)), 1000);
    run_op(2, 2, 1'b1, 1'b0, "clr_start");
    check("clr_start_acc_const", longint'($signed(acc24)), 4);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       a = -128;
        1:       a = 127;
        default: a = int'($signed(8'($urandom)));
      endcase
      case ($urandom_range(0, 5))
        0:       b = -128;
        1:       b = 127;
        default: b = int'($signed(8'($urandom)));
      endcase
      clr = ($urandom_range(0, 7) == 0);
      inj = ($urandom_range(0, 3) == 0);
      run_op(a, b, clr, inj, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(posedge clk); #1;
    check("final_done_low", longint'({done24, done17}), 0);
    check_state("final_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int8_mac_seq.md
INT8_MAC_SEQ -- requirements
Module: int8_mac_seq

Interface
REQ-001 SHALL provide parameter ACC_W, default 24: accumulator width in bits, legal range 17..32.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  input  1  request one multiply-accumulate of in_a*in_b.
REQ-005 SHALL provide port ready  output  1  high when a start will be accepted.
REQ-006 SHALL provide port in_a  input  8  signed multiplicand, two's complement.
REQ-007 SHALL provide port in_b  input  8  signed multiplier, two's complement.
REQ-008 SHALL provide port acc_clr  input  1  zero the accumulator and the sat flag.
REQ-009 SHALL provide port acc  output  ACC_W  signed running sum of products.
REQ-010 SHALL provide port prod  output  16  signed product of the last completed operation.
REQ-011 SHALL provide port done  output  1  one-cycle pulse when acc and prod have updated.
REQ-012 SHALL provide port sat  output  1  sticky flag: accumulator has saturated since last clear.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, SIGN, ACC; ready=1 only in IDLE.
REQ-014 SHALL accept start only in IDLE (edge E0): latch |in_a|, |in_b| and sign = in_a[7]^in_b[7]; go to MUL.
REQ-015 SHALL, in MUL, run 8 shift-add iterations on the unsigned magnitudes, edges E1..E8, using a 3-bit iteration counter; then go to SIGN.
REQ-016 SHALL, in SIGN (edge E9), register prod = sign ? -mag : mag as 16-bit; go to ACC.
REQ-017 SHALL, in ACC (edge E10), register acc = sat_add(acc, sext(prod)), assert done for exactly the cycle after E10, and return to IDLE; the next start is acceptable at E11.
REQ-018 SHALL give a fixed latency of 10 edges from accept to done, independent of operand values.
REQ-019 SHALL treat -128 as magnitude 128 (9-bit magnitude path); (-128)*(-128)=+16384 and (-128)*127=-16256 are exact.
REQ-020 SHALL saturate acc to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow and set sat; sat stays high until acc_clr or reset.
REQ-021 SHALL ignore start while not in IDLE; operands are not re-sampled mid-operation.
REQ-022 SHALL honour acc_clr only in IDLE; acc_clr outside IDLE is ignored.
REQ-023 SHALL, on acc_clr and start in the same IDLE cycle, clear acc and sat first, so the completed operation yields acc = prod.
REQ-024 SHALL hold prod and acc stable between done pulses.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, ready=1, done=0, acc=0, prod=0, sat=0, counter=0, regardless of state.
REQ-026 SHALL discard any operation in flight when reset asserts mid-operation; no done pulse follows release.

Structure
REQ-027 SHALL place the FSM state encoding and the MUL iteration count constant (8) in a shared package for the Extended_DLX datapath.
REQ-028 SHALL take operand magnitudes and the final sign fix from the team's existing conditional-negate block, instantiated twice for operands (enable = sign bit); a 16-bit conditional-negate sub-module, neg16, handles the product.
REQ-029 SHALL keep the shift-add datapath, FSM and saturating adder in the top module; no other sub-modules.

Verification
REQ-030 SHALL cover reset, acc_clr, then start with a=3, b=-5 -> done exactly 10 edges after accept, prod=-15, acc=-15, sat=0.
REQ-031 SHALL cover a=-128, b=-128 then a=-128, b=127 back-to-back -> prod=16384 then -16256; acc=16384 then 128.
REQ-032 SHALL cover ACC_W=17 with repeated 127*127 -> acc clamps at 65535, sat=1; a later acc_clr gives acc=0, sat=0.
REQ-033 SHALL cover start pulsed during MUL with different operands -> ignored, result matches the first operands, exactly one done.
REQ-034 SHALL cover rst_n low at edge E5 of an operation -> outputs at reset values, ready=1, no done after release.
REQ-035 SHALL cover acc_clr and start together with acc=1000, a=2, b=2 -> acc=4 at done.
